// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO on a valid/ready stream.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits.
module uart_tx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          axi_valid,
    output logic                          axi_ready,
    input  logic [DATA_BITS-1:0]          axi_data,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    // Handshake: a word moves on every rising edge where axi_valid && axi_ready;
    // the source holds axi_data stable while axi_valid is high and axi_ready is low.

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          ODD_MODE  = (PARITY == 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t state, state_next;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        level_next;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic [CW-1:0]        baud_cnt;
    logic [3:0]           bit_cnt;
    logic                 baud_wrap;
    logic                 push;
    logic                 pop;
    logic                 line_next;

    assign push       = axi_valid && axi_ready;
    assign baud_wrap  = (baud_cnt == BAUD_LAST);
    assign level_next = fifo_level + LW'(push) - LW'(pop);
    assign busy       = (state != ST_IDLE) || (fifo_level != '0);

    // line_next is the level for the coming cycle; uart_tx registers it.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        line_next  = 1'b1;
        case (state)
            ST_IDLE: begin
                if (fifo_level != '0) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                line_next = 1'b0;
                if (baud_wrap) state_next = ST_DATA;
            end
            ST_DATA: begin
                line_next = shift[0];
                if (baud_wrap && bit_cnt == DATA_LAST)
                    state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                line_next = par_bit;
                if (baud_wrap) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (baud_wrap && bit_cnt == STOP_LAST) begin
                    if (fifo_level != '0) begin
                        pop        = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            uart_tx    <= 1'b1;
            axi_ready  <= 1'b0;
            fifo_level <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
        end else begin
            state      <= state_next;
            uart_tx    <= line_next;
            fifo_level <= level_next;
            axi_ready  <= (level_next != LW'(FIFO_DEPTH));
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);

            if (state == ST_IDLE || baud_wrap) baud_cnt <= '0;
            else                               baud_cnt <= baud_cnt + CW'(1);

            // bit_cnt indexes data bits in DATA and stop bits in STOP.
            if (state_next != state)                  bit_cnt <= '0;
            else if (baud_wrap && state != ST_IDLE)   bit_cnt <= bit_cnt + 4'd1;

            if (pop) begin
                shift   <= mem[rd_ptr];
                par_bit <= (^mem[rd_ptr]) ^ ODD_MODE;
            end else if (state == ST_DATA && baud_wrap) begin
                shift <= shift >> 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= axi_data;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four parameter variants, a frame vector table and
// hand-written sequences for back-pressure, stalls, async reset and divisor 1.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic       valid_a [4];
    logic [8:0] data_a  [4];
    logic       ready_a [4];
    logic       tx_a    [4];
    logic       busy_a  [4];
    logic [2:0] lvl_a   [4];

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q [$];

    // 0: 8N1 /4, 1: 7E2 /4, 2: 7O2 /4, 3: 8N1 /1
    uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .axi_valid(valid_a[0]), .axi_ready(ready_a[0]),
        .axi_data(data_a[0][7:0]), .uart_tx(tx_a[0]), .busy(busy_a[0]), .fifo_level(lvl_a[0]));
    uart_tx_fifo #(.DATA_BITS(7), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .axi_valid(valid_a[1]), .axi_ready(ready_a[1]),
        .axi_data(data_a[1][6:0]), .uart_tx(tx_a[1]), .busy(busy_a[1]), .fifo_level(lvl_a[1]));
    uart_tx_fifo #(.DATA_BITS(7), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .axi_valid(valid_a[2]), .axi_ready(ready_a[2]),
        .axi_data(data_a[2][6:0]), .uart_tx(tx_a[2]), .busy(busy_a[2]), .fifo_level(lvl_a[2]));
    uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst(rst), .axi_valid(valid_a[3]), .axi_ready(ready_a[3]),
        .axi_data(data_a[3][7:0]), .uart_tx(tx_a[3]), .busy(busy_a[3]), .fifo_level(lvl_a[3]));

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected bits written left to right in line order: bit i is exp_bits[nbits-1-i].
    typedef struct {
        int          dut;
        int          cpb;
        logic [8:0]  data;
        int          nbits;
        logic [19:0] exp_bits;
    } vec_t;

    vec_t vecs [7];

    logic [7:0] words [6];
    int         push_edge [6];

    initial begin
        vecs[0] = '{0, 4, 9'h0A5, 10, 20'b0101001011};
        vecs[1] = '{0, 4, 9'h03C, 10, 20'b0001111001};
        vecs[2] = '{1, 4, 9'h055, 11, 20'b01010101011};
        vecs[3] = '{2, 4, 9'h055, 11, 20'b01010101111};
        vecs[4] = '{1, 4, 9'h007, 11, 20'b01110000111};
        vecs[5] = '{2, 4, 9'h000, 11, 20'b00000000111};
        vecs[6] = '{3, 1, 9'h0A5, 10, 20'b0101001011};
        words   = '{8'h5A, 8'hC3, 8'h01, 8'h80, 8'hFF, 8'h3C};

        rst = 1'b1;
        for (int d = 0; d < 4; d++) begin
            valid_a[d] = 1'b0;
            data_a[d]  = 9'h000;
        end

        // ---------------- reset state ----------------
        #1;
        for (int d = 0; d < 4; d++) begin
            check($sformatf("rst_tx%0d", d),    32'(tx_a[d]),    32'h1);
            check($sformatf("rst_ready%0d", d), 32'(ready_a[d]), 32'h0);
            check($sformatf("rst_busy%0d", d),  32'(busy_a[d]),  32'h0);
            check($sformatf("rst_level%0d", d), 32'(lvl_a[d]),   32'h0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_before_first_edge", 32'(ready_a[0]), 32'h0);
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++)
            check($sformatf("ready_after_release%0d", d), 32'(ready_a[d]), 32'h1);

        // ---------------- frame vector table ----------------
        for (int v = 0; v < 7; v++) begin
            int d;
            int cpb;
            int flen;
            d    = vecs[v].dut;
            cpb  = vecs[v].cpb;
            flen = vecs[v].nbits * cpb;
            @(negedge clk);
            check($sformatf("v%0d_ready_idle", v), 32'(ready_a[d]), 32'h1);
            valid_a[d] = 1'b1;
            data_a[d]  = vecs[v].data;
            @(posedge clk);
            #1;
            valid_a[d] = 1'b0;
            data_a[d]  = 9'h1FF;
            check($sformatf("v%0d_push_level", v), 32'(lvl_a[d]), 32'h1);
            for (int t = 1; t <= flen + 1; t++) begin
                @(posedge clk);
                #1;
                if (t == 1) check($sformatf("v%0d_lat_idle", v), 32'(tx_a[d]), 32'h1);
                if (t == 2) check($sformatf("v%0d_lat_start", v), 32'(tx_a[d]), 32'h0);
                if (t >= 2 && ((t - 2) % cpb) == (cpb / 2) && ((t - 2) / cpb) < vecs[v].nbits) begin
                    int i;
                    i = (t - 2) / cpb;
                    check($sformatf("v%0d_bit%0d", v, i), 32'(tx_a[d]),
                          32'(vecs[v].exp_bits[vecs[v].nbits - 1 - i]));
                end
                if (t == flen)     check($sformatf("v%0d_busy_last", v), 32'(busy_a[d]), 32'h1);
                if (t == flen + 1) check($sformatf("v%0d_busy_done", v), 32'(busy_a[d]), 32'h0);
            end
        end

        // ---------------- fill, back-pressure and stalled source on u0 ----------------
        begin
            int   idx;
            int   max_lvl;
            logic rdy_before;
            logic [8:0] cur;
            idx     = 0;
            max_lvl = 0;
            cur     = 9'h000;
            @(negedge clk);
            valid_a[0] = 1'b1;
            data_a[0]  = {1'b0, words[0]};
            for (int t = 1; t <= 245; t++) begin
                rdy_before = ready_a[0];
                @(posedge clk);
                #1;
                if (valid_a[0] && rdy_before) begin
                    push_edge[idx] = t;
                    exp_q.push_back(data_a[0]);
                    idx++;
                end
                if (idx >= 6) begin
                    valid_a[0] = 1'b0;
                end else if (ready_a[0]) begin
                    data_a[0] = {1'b0, words[idx]};
                end else begin
                    data_a[0] = 9'($urandom_range(0, 255));
                end
                if (int'(lvl_a[0]) > max_lvl) max_lvl = int'(lvl_a[0]);
                if (lvl_a[0] == 3'd4) check("ready_low_when_full", 32'(ready_a[0]), 32'h0);
                if (t >= 3) begin
                    int u;
                    int j;
                    int r;
                    u = t - 3;
                    j = u / 40;
                    r = u % 40;
                    if (j < 6 && (r % 4) == 2) begin
                        int   i;
                        logic eb;
                        i = r / 4;
                        if (i == 0) begin
                            if (exp_q.size() == 0) begin
                                check($sformatf("fill_queue_empty_f%0d", j), 32'h1, 32'h0);
                                cur = 9'h000;
                            end else begin
                                cur = exp_q.pop_front();
                            end
                        end
                        if (i == 0)      eb = 1'b0;
                        else if (i == 9) eb = 1'b1;
                        else             eb = cur[i - 1];
                        check($sformatf("fill_f%0d_bit%0d", j, i), 32'(tx_a[0]), 32'(eb));
                    end
                end
                if (t == 241) check("fill_busy_last", 32'(busy_a[0]), 32'h1);
                if (t == 242) check("fill_busy_done", 32'(busy_a[0]), 32'h0);
            end
            valid_a[0] = 1'b0;
            check("fill_words_accepted", 32'(idx), 32'd6);
            check("fill_max_level", 32'(max_lvl), 32'd4);
            for (int k = 0; k < 5; k++)
                check($sformatf("fill_push_edge%0d", k), 32'(push_edge[k]), 32'(k + 1));
            check("fill_push_edge5", 32'(push_edge[5]), 32'd43);
            check("fill_queue_drained", 32'(exp_q.size()), 32'd0);
        end

        // ---------------- minimum divisor on u3 ----------------
        begin
            logic [19:0] pat;
            pat = 20'b00000000010111111111;
            @(negedge clk);
            valid_a[3] = 1'b1;
            data_a[3]  = 9'h000;
            @(posedge clk);
            #1;
            data_a[3] = 9'h0FF;
            @(posedge clk);
            #1;
            valid_a[3] = 1'b0;
            check("min_lat_idle", 32'(tx_a[3]), 32'h1);
            for (int t = 3; t <= 23; t++) begin
                @(posedge clk);
                #1;
                if (t <= 22) check($sformatf("min_bit%0d", t - 3), 32'(tx_a[3]), 32'(pat[19 - (t - 3)]));
                else begin
                    check("min_idle_after", 32'(tx_a[3]), 32'h1);
                    check("min_busy_after", 32'(busy_a[3]), 32'h0);
                end
            end
        end

        // ---------------- asynchronous reset mid-frame on u0 ----------------
        @(negedge clk);
        valid_a[0] = 1'b1;
        data_a[0]  = 9'h000;
        for (int t = 1; t <= 20; t++) begin
            @(posedge clk);
            #1;
            if (t == 1) data_a[0] = 9'h012;
            if (t == 2) data_a[0] = 9'h034;
            if (t == 3) data_a[0] = 9'h056;
            if (t == 4) begin
                valid_a[0] = 1'b0;
                check("arst_level_queued", 32'(lvl_a[0]), 32'd3);
            end
        end
        #2;
        check("arst_tx_in_data", 32'(tx_a[0]), 32'h0);
        rst = 1'b1;
        #1;
        check("arst_tx_immediate",    32'(tx_a[0]),    32'h1);
        check("arst_level_immediate", 32'(lvl_a[0]),   32'h0);
        check("arst_busy_immediate",  32'(busy_a[0]),  32'h0);
        check("arst_ready_immediate", 32'(ready_a[0]), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("arst_ready_held", 32'(ready_a[0]), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_ready_pre_edge", 32'(ready_a[0]), 32'h0);
        @(posedge clk);
        #1;
        check("arst_ready_post_edge", 32'(ready_a[0]), 32'h1);
        for (int t = 0; t < 80; t++) begin
            check($sformatf("arst_no_remnant_tx%0d", t), 32'(tx_a[0]), 32'h1);
            if (t % 10 == 0) check($sformatf("arst_no_remnant_busy%0d", t), 32'(busy_a[0]), 32'h0);
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
